// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// Optional grant locking enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter #(
   parameter int DATA_W  = 16,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*2-1:0]      req_op,
   input  logic [NUM_REQ-1:0]        req_lock,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [1:0]                alu_op,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_zero,
   input  logic                      alu_carry,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_zero,
   output logic                      resp_carry
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [DATA_W-1:0]  a_q, b_q;
   logic [1:0]         op_q;
   logic [ID_W-1:0]    id_q;
   logic [DATA_W-1:0]  data_q;
   logic               zero_q, carry_q;

   logic               found;
   int                 gnt_idx;
   int                 idx;
   int                 nxt;
   logic [DATA_W-1:0]  a_sel, b_sel;
   logic [1:0]         op_sel;
   logic               lock_sel;
   logic               accept;

`ifdef ALU_ARB_LOCK_EN
   logic               lock_q;
   logic [ID_W-1:0]    lkid_q;
`else
   logic               unused_lock;
   assign unused_lock = ^req_lock;
`endif

   // First valid requester at or after rr_q, wrapping modulo NUM_REQ
   always_comb begin
      found   = 1'b0;
      gnt_idx = 0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && j == idx && req_valid[j]) begin
               found   = 1'b1;
               gnt_idx = j;
            end
         end
      end
`ifdef ALU_ARB_LOCK_EN
      for (int j = 0; j < NUM_REQ; j++) begin
         if (lock_q && j == int'(lkid_q) && req_valid[j]) begin
            found   = 1'b1;
            gnt_idx = j;
         end
      end
`endif
   end

   always_comb begin
      a_sel    = '0;
      b_sel    = '0;
      op_sel   = 2'b00;
      lock_sel = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (j == gnt_idx) begin
            a_sel    = req_a[j*DATA_W +: DATA_W];
            b_sel    = req_b[j*DATA_W +: DATA_W];
            op_sel   = req_op[j*2 +: 2];
            lock_sel = req_lock[j];
         end
      end
      nxt = gnt_idx + 1;
      if (nxt >= NUM_REQ) nxt = 0;
`ifdef ALU_ARB_LOCK_EN
      rr_d = lock_sel ? rr_q : ID_W'(nxt);
`else
      rr_d = ID_W'(nxt);
`endif
   end

   assign accept = (state_q == IDLE) && found && !rst;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         req_ready[j] = accept && (j == gnt_idx);
      end
      alu_a      = (state_q == EXEC) ? a_q  : '0;
      alu_b      = (state_q == EXEC) ? b_q  : '0;
      alu_op     = (state_q == EXEC) ? op_q : 2'b00;
      resp_valid = (state_q == RESP);
      resp_id    = id_q;
      resp_data  = data_q;
      resp_zero  = zero_q;
      resp_carry = carry_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 2'b00;
         id_q    <= '0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
         lock_q  <= 1'b0;
         lkid_q  <= '0;
`endif
      end else begin
         if (accept) begin
            a_q  <= a_sel;
            b_q  <= b_sel;
            op_q <= op_sel;
            id_q <= ID_W'(gnt_idx);
            rr_q <= rr_d;
`ifdef ALU_ARB_LOCK_EN
            lock_q <= lock_sel;
            lkid_q <= ID_W'(gnt_idx);
`endif
         end
         if (state_q == EXEC) begin
            data_q  <= alu_out;
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Directed latency, stall, reset and arbitration-order checks.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, req_lock;
   logic [31:0] req_a, req_b;
   logic [3:0]  req_op;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_op;
   logic        alu_zero, alu_carry;
   logic        resp_valid, resp_ready;
   logic [1:0]  resp_id;
   logic [15:0] resp_data;
   logic        resp_zero, resp_carry;

   alu_arbiter #(.DATA_W(16), .NUM_REQ(2), .ID_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .req_lock(req_lock),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .alu_carry(alu_carry),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data),
      .resp_zero(resp_zero), .resp_carry(resp_carry)
   );

   always #5 clk = ~clk;

   // ALU model: its own carry flag feeds back as carry-in
   logic        cq;
   logic [16:0] sum;
   always_comb begin
      sum       = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, cq};
      alu_carry = cq;
      case (alu_op)
         2'b01: begin alu_out = sum[15:0]; alu_carry = sum[16]; end
         2'b10: alu_out = alu_a - alu_b;
         2'b11: alu_out = ~(alu_a & alu_b);
         default: alu_out = 16'd0;
      endcase
      alu_zero = (alu_op == 2'b10) ? (alu_a == alu_b) : (alu_out == 16'd0);
   end
   always_ff @(posedge clk) begin
      if (rst) cq <= 1'b0;
      else if (alu_op == 2'b01) cq <= sum[16];
   end

   typedef struct {
      logic [1:0]  id;
      logic [1:0]  op;
      logic [15:0] d;
      logic        z;
      logic        c;
   } exp_t;

   exp_t sb[$];
   int   gnt_log[$];
   int   gnt_t[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   logic m_carry = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Push expectations on acceptance, pop on response handshake
   initial forever begin
      @(negedge clk);
      if (rst) begin
         sb.delete();
         m_carry = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_t e;
               logic [15:0] a, b;
               logic [16:0] s;
               a    = req_a[i*16 +: 16];
               b    = req_b[i*16 +: 16];
               e.id = 2'(i);
               e.op = req_op[i*2 +: 2];
               e.d  = 16'd0;
               e.z  = (a == b);
               e.c  = m_carry;
               if (e.op == 2'b01) begin
                  s = {1'b0, a} + {1'b0, b} + {16'd0, m_carry};
                  e.d = s[15:0];
                  e.c = s[16];
                  m_carry = s[16];
               end else if (e.op == 2'b11) begin
                  e.d = ~(a & b);
               end
               sb.push_back(e);
               gnt_log.push_back(i);
               gnt_t.push_back(cyc);
            end
         end
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 32'(resp_id), 32'hDEAD);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_id", 32'(resp_id), 32'(e.id));
               if (e.op == 2'b01 || e.op == 2'b11)
                  chk("sb_data", 32'(resp_data), 32'(e.d));
               if (e.op == 2'b10)
                  chk("sb_zero", 32'(resp_zero), 32'(e.z));
               if (e.op == 2'b01)
                  chk("sb_carry", 32'(resp_carry), 32'(e.c));
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] op);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
      req_op[i*2 +: 2]  = op;
      req_valid[i]      = 1'b1;
   endtask

   task automatic wait_ready(input int i);
      int t = 0;
      @(negedge clk);
      while (!req_ready[i] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready[i]) chk("acc_timeout", 32'(req_ready), 32'(1 << i));
   endtask

   task automatic wait_resp();
      int t = 0;
      @(negedge clk);
      while (!resp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 1);
   endtask

   task automatic wait_gnt(input int n);
      int t = 0;
      while (gnt_log.size() < n && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (gnt_log.size() < n) chk("gnt_timeout", gnt_log.size(), n);
   endtask

   task automatic run_op(input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] op);
      @(posedge clk); #1;
      set_req(i, a, b, op);
      wait_ready(i);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
      wait_resp();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_lock   = '0;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Reset while holding a response
      resp_ready = 1'b0;
      set_req(0, 16'd3, 16'd3, 2'b10);
      wait_ready(0);
      @(posedge clk); #1 req_valid = '0;
      wait_resp();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rrst_resp_valid", 32'(resp_valid), 0);
      chk("rrst_alu_op", 32'(alu_op), 0);
      @(posedge clk); #1 rst = 1'b0;
      resp_ready = 1'b1;
      set_req(0, 16'd1, 16'd2, 2'b10);
      set_req(1, 16'd1, 16'd2, 2'b10);
      @(negedge clk);
      chk("rrst_first_gnt", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      wait_resp();
      @(posedge clk); #1;

      // Latency of a single add
      set_req(0, 16'd25, 16'd40, 2'b01);
      @(negedge clk);
      chk("lat_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      chk("lat_alu_op", 32'(alu_op), 1);
      chk("lat_alu_a", 32'(alu_a), 25);
      chk("lat_alu_b", 32'(alu_b), 40);
      chk("lat_no_resp", 32'(resp_valid), 0);
      @(negedge clk);
      chk("lat_resp_valid", 32'(resp_valid), 1);
      chk("lat_resp_id", 32'(resp_id), 0);
      chk("lat_resp_data", 32'(resp_data), 65);
      chk("lat_resp_carry", 32'(resp_carry), 0);
      chk("lat_alu_idle", 32'(alu_op), 0);
      @(negedge clk);
      chk("lat_back_idle", 32'(resp_valid), 0);

      // Compare equal / unequal from requester 1
      run_op(1, 16'd7, 16'd7, 2'b10);
      run_op(1, 16'd7, 16'd8, 2'b10);

      // Alternating grants with carry chaining on requester 0
      do_reset();
      gnt_log.delete();
      gnt_t.delete();
      set_req(0, 16'hFFFF, 16'h0001, 2'b01);
      set_req(1, 16'hF0F0, 16'hFF00, 2'b11);
      repeat (13) @(negedge clk);
      @(posedge clk); #1 req_valid = '0;
      repeat (6) @(posedge clk);
      chk("rr_count", 32'(gnt_log.size() >= 4), 1);
      for (int k = 0; k < 4; k++)
         chk("rr_order", gnt_log[k], k % 2);
      for (int k = 0; k < 3; k++)
         chk("rr_spacing", gnt_t[k+1] - gnt_t[k], 3);

      // Backpressure on the response channel
      @(posedge clk); #1 resp_ready = 1'b0;
      set_req(0, 16'h1234, 16'h0F0F, 2'b11);
      wait_ready(0);
      @(posedge clk); #1 req_valid = '0;
      wait_resp();
      @(posedge clk); #1;
      set_req(0, 16'd1, 16'd1, 2'b10);
      set_req(1, 16'd1, 16'd1, 2'b10);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 1);
         chk("bp_data", 32'(resp_data), 32'h0000FDFB);
         chk("bp_id", 32'(resp_id), 0);
         chk("bp_no_ready", 32'(req_ready), 0);
      end
      @(posedge clk); #1 req_valid = '0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", 32'(resp_valid), 1);
      @(negedge clk);
      chk("bp_idle", 32'(resp_valid), 0);

      // Grant lock on requester 0
      do_reset();
      gnt_log.delete();
      gnt_t.delete();
      req_lock = 2'b01;
      set_req(0, 16'd5, 16'd6, 2'b10);
      set_req(1, 16'd5, 16'd5, 2'b10);
      wait_gnt(1);
      @(posedge clk); #1 req_lock = '0;
      wait_gnt(3);
      @(posedge clk); #1 req_valid = '0;
      repeat (6) @(posedge clk);
      chk("lock_g0", gnt_log[0], 0);
`ifdef ALU_ARB_LOCK_EN
      chk("lock_g1", gnt_log[1], 0);
      chk("lock_g2", gnt_log[2], 1);
`else
      chk("lock_g1", gnt_log[1], 1);
      chk("lock_g2", gnt_log[2], 0);
`endif
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
